ws2812_chain: RTL and testbench
===============================

// Module: ws2812_chain
// PURPOSE
//  Parametrised WS2812/SK6812 LED-chain driver: holds a frame buffer of NUM_LEDS words,
//  serialises it on a single data pin with configurable bit timing and latch time.
//  Adds over the previous driver: RGBW (32-bit) support, global brightness scaling,
//  one-shot frames on a start/busy/done handshake, or free-running refresh.
//  Sits between a host register/bus interface and the LED output pad.
// PARAMETERS
//  NUM_LEDS      8     LEDs in chain (>=1); frame buffer depth
//  BITS_PER_LED  24    24 (GRB) or 32 (GRBW); any other value is a elaboration error
//  CLK_MHZ       12    clock frequency, integer MHz
//  T0H_NS        350   high time of a '0' bit
//  T1H_NS        900   high time of a '1' bit
//  PERIOD_NS     1250  total bit period
//  LATCH_US      280   low time after last bit (latch/reset)
//  AUTO_REFRESH  0     0: frame only on start; 1: restart frame immediately after latch
// PORTS
//  clk         in   1             system clock
//  reset_n     in   1             synchronous reset, active low
//  wr_en       in   1             write frame-buffer word
//  wr_addr     in   LED_BITS      LED index (LED_BITS = max(1,$clog2(NUM_LEDS)))
//  wr_data     in   BITS_PER_LED  colour word, transmitted MSB first
//  brightness  in   8             global scale, 255 = unscaled
//  start       in   1             request one frame (ignored when AUTO_REFRESH=1)
//  busy        out  1             frame (data or latch phase) in progress
//  done        out  1             one-cycle pulse at end of latch phase
//  data        out  1             serial output to LED chain
// BEHAVIOUR
//  Timing counts: N = ceil(CLK_MHZ*ns/1000); latch = CLK_MHZ*LATCH_US. Requires T0H<T1H<PERIOD.
//  Reset (reset_n=0 at edge): state=IDLE, data=0, busy=0, done=0, counters cleared.
//   Frame buffer NOT reset (must infer BRAM); contents undefined until written.
//  Writes: wr_en with wr_addr<NUM_LEDS stores wr_data next edge; wr_addr>=NUM_LEDS ignored.
//   Writes allowed at any time, including mid-frame.
//  FSM: IDLE -> FETCH -> SCALE -> DATA -> (FETCH | LATCH) -> IDLE/FETCH.
//   IDLE: data=0. start=1 (or AUTO_REFRESH=1) -> FETCH, busy=1 after same edge,
//         led_idx=0, brightness sampled into register for whole frame.
//   FETCH: issue buffer read of led_idx (1-cycle sync read).
//   SCALE: each byte c -> (c*(bright+1))>>8, 8x9-bit mult per byte; result into shift reg.
//   DATA: BITS_PER_LED bits, MSB first; each bit PERIOD counts; data=1 for first T1H
//         counts if bit=1, T0H counts if bit=0, else 0. After last bit of LED:
//         led_idx<NUM_LEDS-1 -> FETCH (led_idx+1); else -> LATCH.
//   LATCH: data=0 for latch counts; then done=1 for one cycle; -> IDLE (AUTO_REFRESH=0)
//         or FETCH with led_idx=0 and brightness resampled (AUTO_REFRESH=1). busy stays 1
//         through LATCH, drops the edge done asserts (AUTO_REFRESH=0).
//  Inter-LED gap: FETCH+SCALE add exactly 2 low cycles between LEDs (within WS2812 tolerance).
//  Latency: start at edge k -> busy=1 after k, first data rise after edge k+3.
//  Snapshot: each LED word is read at its FETCH; a write to that LED after FETCH
//   appears next frame; a write to a later LED before its FETCH appears this frame.
//  start while busy: ignored (no queueing). start and reset_n=0 same edge: reset wins.
//  reset_n=0 mid-frame: data=0 next edge, frame aborted, no done pulse.
//  Simultaneous wr_en and FETCH of same address: read returns OLD word.
// STRUCTURE
//  ws2812_pkg: timing-count function (ceil ns->cycles), state encodings, LED_BITS calc.
//  Sub-module ws2812_bit_tx: period counter + high-time compare; inputs bit value and
//   bit_start, outputs data and bit_done. Top holds buffer, FSM, scaler, shift register.
// TESTING (CLK_MHZ=12: T0H=5, T1H=11, PERIOD=15, latch=3360)
//  Write LED0=0xFF0000, LED1..7=0, brightness=255, start -> LED0 first 8 bits 11-high/
//   4-low, rest 5-high/10-low; 3360 low cycles; done pulse; busy=0.
//  brightness=127, LED0=0x80FF01 -> transmitted 0x407F00; brightness=0 -> all zeros.
//  BITS_PER_LED=32, NUM_LEDS=1, word 0xA5A5A5A5 -> 32 bits exact pattern, 1 done pulse.
//  start pulsed again during DATA and LATCH -> ignored; single done; next start works.
//  reset_n=0 mid LED3 -> data=0 next edge, busy=0, no done; restart sends from LED0.
//  AUTO_REFRESH=1, write LED5 during LED2 -> new value in current frame; continuous frames.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812/SK6812 chain driver: FSM encoding,
// ns-to-cycle conversion, address width and the per-byte brightness scaler.
package ws2812_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_SCALE = 3'd2,
      ST_DATA  = 3'd3,
      ST_LATCH = 3'd4
   } state_t;

   function automatic int ns_to_cycles(input int clk_mhz, input int ns);
      return (clk_mhz * ns + 32'sd999) / 32'sd1000;
   endfunction

   function automatic int led_bits(input int n);
      return (n > 32'sd1) ? $clog2(n) : 32'sd1;
   endfunction

   // (c * (b + 1)) >> 8, so 255 passes the colour through untouched
   function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] w_prod;
      w_prod = {8'd0, c} * {7'd0, ({1'b0, b} + 9'd1)};
      return 8'(w_prod >> 8);
   endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Single-bit waveform generator: one bit_start launches a full bit period whose
// high time depends on the bit value; bit_done flags the last cycle of the period.
module ws2812_bit_tx
   import ws2812_pkg::*;
#(
   parameter int T0H_CYC    = 5,
   parameter int T1H_CYC    = 11,
   parameter int PERIOD_CYC = 15
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_bit,
   input  logic i_bit_start,
   output logic o_data,
   output logic o_bit_done
);

   localparam int CW = $clog2(PERIOD_CYC + 1);

   logic [CW-1:0] r_cnt;
   logic          r_bit;
   logic          r_active;
   logic          r_data;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_high_len;

   // Next count and the high-time threshold for the bit in flight
   always_comb begin
      w_cnt_nxt  = r_cnt + CW'(1);
      w_high_len = r_bit ? CW'(T1H_CYC) : CW'(T0H_CYC);
   end

   // Period counter; a start landing on the last cycle chains bits back to back
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_cnt    <= '0;
         r_bit    <= 1'b0;
         r_active <= 1'b0;
         r_data   <= 1'b0;
      end else if (i_bit_start) begin
         r_cnt    <= '0;
         r_bit    <= i_bit;
         r_active <= 1'b1;
         r_data   <= 1'b1;
      end else if (r_active) begin
         if (r_cnt == CW'(PERIOD_CYC - 1)) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_data   <= 1'b0;
         end else begin
            r_cnt  <= w_cnt_nxt;
            r_data <= (w_cnt_nxt < w_high_len);
         end
      end else begin
         r_data <= 1'b0;
      end
   end

   assign o_data     = r_data;
   assign o_bit_done = r_active && (r_cnt == CW'(PERIOD_CYC - 1));

endmodule

// File: rtl/ws2812_chain.sv
// WS2812/SK6812 chain driver: frame buffer, brightness scaler and frame FSM
// feeding a bit waveform generator, with one-shot or free-running refresh.
module ws2812_chain
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS     = 8,
   parameter int BITS_PER_LED = 24,
   parameter int CLK_MHZ      = 12,
   parameter int T0H_NS       = 350,
   parameter int T1H_NS       = 900,
   parameter int PERIOD_NS    = 1250,
   parameter int LATCH_US     = 280,
   parameter int AUTO_REFRESH = 0,
   localparam int LED_BITS    = led_bits(NUM_LEDS)
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_wr_en,
   input  logic [LED_BITS-1:0]     i_wr_addr,
   input  logic [BITS_PER_LED-1:0] i_wr_data,
   input  logic [7:0]              i_brightness,
   input  logic                    i_start,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_data
);

   localparam int T0H_CYC    = ns_to_cycles(CLK_MHZ, T0H_NS);
   localparam int T1H_CYC    = ns_to_cycles(CLK_MHZ, T1H_NS);
   localparam int PERIOD_CYC = ns_to_cycles(CLK_MHZ, PERIOD_NS);
   localparam int LATCH_CYC  = CLK_MHZ * LATCH_US;
   localparam int LW         = $clog2(LATCH_CYC + 1);
   localparam int BW         = $clog2(BITS_PER_LED);
   localparam int DEPTH      = 1 << LED_BITS;
   localparam int NBYTES     = BITS_PER_LED / 8;

   if (!(BITS_PER_LED == 24 || BITS_PER_LED == 32)) begin : g_bad_width
      $error("ws2812_chain: BITS_PER_LED must be 24 or 32");
   end
   if (!(T0H_CYC < T1H_CYC && T1H_CYC < PERIOD_CYC)) begin : g_bad_timing
      $error("ws2812_chain: bit timing must satisfy T0H < T1H < PERIOD");
   end

   state_t                  r_state;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_data;
   logic [LED_BITS-1:0]     r_idx;
   logic [BW-1:0]           r_bit_cnt;
   logic [LW-1:0]           r_latch_cnt;
   logic [7:0]              r_bright;
   logic [BITS_PER_LED-1:0] r_mem [DEPTH];
   logic [BITS_PER_LED-1:0] r_rd_word;
   logic [BITS_PER_LED-1:0] r_shift;
   logic [BITS_PER_LED-1:0] w_scaled;
   logic                    w_wr_ok;
   logic                    w_last_bit;
   logic                    w_last_led;
   logic                    w_bit_start;
   logic                    w_tx_bit;
   logic                    w_tx_data;
   logic                    w_bit_done;

   for (genvar g = 0; g < NBYTES; g++) begin : g_scale
      assign w_scaled[g*8 +: 8] = scale_byte(r_rd_word[g*8 +: 8], r_bright);
   end

   // Bit launch: MSB goes out straight from the scaler so FETCH+SCALE cost only two cycles
   always_comb begin
      w_wr_ok     = i_wr_en && (32'(i_wr_addr) < NUM_LEDS);
      w_last_bit  = (r_bit_cnt == BW'(BITS_PER_LED - 1));
      w_last_led  = (r_idx == LED_BITS'(NUM_LEDS - 1));
      w_tx_bit    = r_shift[BITS_PER_LED-1];
      w_bit_start = 1'b0;
      if (r_state == ST_SCALE) begin
         w_bit_start = 1'b1;
         w_tx_bit    = w_scaled[BITS_PER_LED-1];
      end else if (r_state == ST_DATA && w_bit_done && !w_last_bit) begin
         w_bit_start = 1'b1;
      end else begin
         w_bit_start = 1'b0;
      end
   end

   // Frame buffer without reset; read-before-write returns the old word on a collision
   always_ff @(posedge i_clk) begin
      if (w_wr_ok) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      if (r_state == ST_FETCH) begin
         r_rd_word <= r_mem[r_idx];
      end
   end

   // Frame sequencer
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_idx       <= '0;
         r_bit_cnt   <= '0;
         r_latch_cnt <= '0;
         r_bright    <= 8'd0;
         r_shift     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start || (AUTO_REFRESH != 0)) begin
                  r_state  <= ST_FETCH;
                  r_busy   <= 1'b1;
                  r_idx    <= '0;
                  r_bright <= i_brightness;
               end else begin
                  r_busy <= 1'b0;
               end
            end
            ST_FETCH: r_state <= ST_SCALE;
            ST_SCALE: begin
               r_shift   <= {w_scaled[BITS_PER_LED-2:0], 1'b0};
               r_bit_cnt <= '0;
               r_state   <= ST_DATA;
            end
            ST_DATA: begin
               if (w_bit_done) begin
                  if (!w_last_bit) begin
                     r_bit_cnt <= r_bit_cnt + BW'(1);
                     r_shift   <= {r_shift[BITS_PER_LED-2:0], 1'b0};
                  end else if (!w_last_led) begin
                     r_idx   <= r_idx + LED_BITS'(1);
                     r_state <= ST_FETCH;
                  end else begin
                     r_latch_cnt <= '0;
                     r_state     <= ST_LATCH;
                  end
               end
            end
            ST_LATCH: begin
               if (r_latch_cnt == LW'(LATCH_CYC)) begin
                  r_latch_cnt <= '0;
                  r_done      <= 1'b1;
                  if (AUTO_REFRESH != 0) begin
                     r_state  <= ST_FETCH;
                     r_idx    <= '0;
                     r_bright <= i_brightness;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_latch_cnt <= r_latch_cnt + LW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Pad register
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_data <= 1'b0;
      end else begin
         r_data <= w_tx_data;
      end
   end

   ws2812_bit_tx #(
      .T0H_CYC    (T0H_CYC),
      .T1H_CYC    (T1H_CYC),
      .PERIOD_CYC (PERIOD_CYC)
   ) u_bit_tx (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_bit       (w_tx_bit),
      .i_bit_start (w_bit_start),
      .o_data      (w_tx_data),
      .o_bit_done  (w_bit_done)
   );

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_data = r_data;

endmodule

// File: tb/tb_ws2812_chain.sv
// Bench for ws2812_chain: three instances (GRB x8, GRBW x1, auto-refresh GRB x8)
// share one pin decoder that pops expected high/low run lengths from a scoreboard.
module tb_ws2812_chain;
   localparam int LATCH = 3360;

   logic        clk = 1'b0;
   logic        rst0, rst1, rst2;
   logic        wr0, wr1, wr2;
   logic        st0, st1, st2;
   logic [2:0]  wr_addr;
   logic [31:0] wr_data;
   logic [7:0]  bright;
   logic        busy0, done0, data0;
   logic        busy1, done1, data1;
   logic        busy2, done2, data2;

   always #5 clk = ~clk;

   ws2812_chain dut0 (
      .i_clk(clk), .i_reset_n(rst0), .i_wr_en(wr0), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data[23:0]), .i_brightness(bright), .i_start(st0),
      .o_busy(busy0), .o_done(done0), .o_data(data0));

   ws2812_chain #(.NUM_LEDS(1), .BITS_PER_LED(32)) dut32 (
      .i_clk(clk), .i_reset_n(rst1), .i_wr_en(wr1), .i_wr_addr(wr_addr[0:0]),
      .i_wr_data(wr_data), .i_brightness(bright), .i_start(st1),
      .o_busy(busy1), .o_done(done1), .o_data(data1));

   ws2812_chain #(.AUTO_REFRESH(1)) dut_ar (
      .i_clk(clk), .i_reset_n(rst2), .i_wr_en(wr2), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data[23:0]), .i_brightness(bright), .i_start(st2),
      .o_busy(busy2), .o_done(done2), .o_data(data2));

   typedef struct {
      int hi;
      int lo;
   } item_t;

   item_t       sb_q[$];
   item_t       cur;
   int          n_checks = 0;
   int          n_pass = 0;
   int          sel = 0;
   bit          mon_en = 1'b0;
   bit          have = 1'b0;
   int          hi_cnt = 0;
   int          lo_cnt = 0;
   int          done_count = 0;
   logic [31:0] model [8];
   logic        m_data, m_done;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   always_comb begin
      case (sel)
         1:       begin m_data = data1; m_done = done1; end
         2:       begin m_data = data2; m_done = done2; end
         default: begin m_data = data0; m_done = done0; end
      endcase
   end

   // Pin decoder: high run of each bit, low run after it (or up to done for the last bit)
   always @(negedge clk) begin
      if (m_done === 1'b1) done_count++;
      if (!mon_en) begin
         hi_cnt = 0; lo_cnt = 0; have = 1'b0;
      end else if (m_done === 1'b1) begin
         if (have) check_eq("latch_low", lo_cnt, cur.lo);
         have = 1'b0; lo_cnt = 0;
      end else if (m_data === 1'b1) begin
         if (have && hi_cnt == 0) begin
            check_eq("low_time", lo_cnt, cur.lo);
            have = 1'b0;
         end
         hi_cnt++;
      end else if (hi_cnt > 0) begin
         check_eq("sb_avail", sb_q.size() > 0, 1);
         if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            check_eq("high_time", hi_cnt, cur.hi);
            have = 1'b1;
         end
         hi_cnt = 0; lo_cnt = 1;
      end else if (have) begin
         lo_cnt++;
      end
   end

   function automatic int scale_ref(input int c, input int b);
      return (c * (b + 1)) / 256;
   endfunction

   task automatic push_frame(input int nleds, input int bits, input int br);
      logic [31:0] sw;
      item_t       it;
      for (int led = 0; led < nleds; led++) begin
         sw = 32'd0;
         for (int j = 0; j < bits / 8; j++)
            sw = sw | (32'(scale_ref(int'((model[led] >> (8 * j)) & 32'hFF), br)) << (8 * j));
         for (int i = bits - 1; i >= 0; i--) begin
            it.hi = sw[i] ? 11 : 5;
            it.lo = 15 - it.hi + ((i == 0) ? ((led == nleds - 1) ? LATCH : 2) : 0);
            sb_q.push_back(it);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic write_led(input int which, input int addr, input logic [31:0] d);
      wr_addr = 3'(addr); wr_data = d;
      wr0 = (which == 0); wr1 = (which == 1); wr2 = (which == 2);
      tick();
      wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
   endtask

   task automatic pulse_start(input int which);
      st0 = (which == 0); st1 = (which == 1);
      tick();
      st0 = 1'b0; st1 = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      for (int i = 0; i < budget && done_count < target; i++) begin
         @(negedge clk); #1;
      end
      check_eq("done_wait", done_count, target);
   endtask

   task automatic wait_q(input int left, input int budget);
      for (int i = 0; i < budget && sb_q.size() > left; i++) begin
         @(negedge clk); #1;
      end
      check_eq("q_wait", sb_q.size() <= left, 1);
   endtask

   initial begin
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
      st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
      wr_addr = 3'd0; wr_data = 32'd0; bright = 8'd255;
      repeat (3) tick();
      check_eq("rst_busy", busy0, 1'b0);
      check_eq("rst_done", done0, 1'b0);
      check_eq("rst_data", data0, 1'b0);
      rst0 = 1'b1; rst1 = 1'b1;
      tick();

      // full-brightness frame, LED0 red only, plus start latency
      for (int i = 0; i < 8; i++) begin
         model[i] = (i == 0) ? 32'h00FF0000 : 32'd0;
         write_led(0, i, model[i]);
      end
      sel = 0; mon_en = 1'b1;
      push_frame(8, 24, 255);
      pulse_start(0);
      @(negedge clk);
      check_eq("start_busy", busy0, 1'b1);
      @(negedge clk); @(negedge clk);
      check_eq("rise_early", data0, 1'b0);
      @(negedge clk);
      check_eq("rise_k3", data0, 1'b1);
      wait_done(1, 8000);
      check_eq("done_busy", busy0, 1'b0);
      check_eq("done_pulse", done0, 1'b1);
      @(negedge clk); #1;
      check_eq("done_width", done0, 1'b0);
      check_eq("drain_a", sb_q.size(), 0);

      // brightness 127 with starts ignored in DATA and LATCH
      model[0] = 32'h0080FF01;
      write_led(0, 0, model[0]);
      bright = 8'd127;
      push_frame(8, 24, 127);
      pulse_start(0);
      repeat (200) tick();
      pulse_start(0);
      wait_q(0, 4000);
      repeat (100) tick();
      pulse_start(0);
      wait_done(2, 8000);
      repeat (60) tick();
      check_eq("no_requeue", done_count, 2);
      check_eq("idle_after", busy0, 1'b0);

      // brightness 0 blanks everything
      bright = 8'd0;
      push_frame(8, 24, 0);
      pulse_start(0);
      wait_done(3, 8000);
      check_eq("drain_c", sb_q.size(), 0);

      // reset during LED3 aborts the frame, restart sends from LED0
      bright = 8'd255;
      model[3] = 32'h0000FF00;
      write_led(0, 3, model[3]);
      push_frame(8, 24, 255);
      pulse_start(0);
      wait_q(8 * 24 - (3 * 24 + 6), 4000);
      for (int i = 0; i < 40 && data0 !== 1'b1; i++) @(negedge clk);
      #1 rst0 = 1'b0; mon_en = 1'b0;
      @(negedge clk);
      check_eq("abort_data", data0, 1'b0);
      check_eq("abort_busy", busy0, 1'b0);
      sb_q.delete();
      repeat (3) tick();
      rst0 = 1'b1;
      repeat (4000) tick();
      check_eq("abort_nodone", done_count, 3);
      mon_en = 1'b1;
      push_frame(8, 24, 255);
      pulse_start(0);
      wait_done(4, 8000);
      check_eq("drain_d", sb_q.size(), 0);

      // 32-bit GRBW, single LED
      sel = 1;
      model[0] = 32'hA5A5A5A5;
      write_led(1, 0, model[0]);
      push_frame(1, 32, 255);
      pulse_start(1);
      wait_done(5, 8000);
      check_eq("busy32", busy1, 1'b0);
      check_eq("drain_e", sb_q.size(), 0);

      // auto refresh: LED5 rewritten during LED2 shows in the current frame
      mon_en = 1'b0; sel = 2; bright = 8'd200;
      for (int i = 0; i < 8; i++) begin
         model[i] = 32'h00111111 * 32'(i) + 32'h0000000F;
         write_led(2, i, model[i]);
      end
      write_led(2, 5, 32'h00555555);
      model[5] = 32'h00C3A5F0;
      push_frame(8, 24, 200);
      push_frame(8, 24, 200);
      mon_en = 1'b1;
      rst2 = 1'b1;
      wait_q(2 * 192 - (2 * 24 + 4), 4000);
      write_led(2, 5, model[5]);
      wait_done(6, 8000);
      check_eq("ar_busy", busy2, 1'b1);
      wait_done(7, 8000);
      rst2 = 1'b0;
      check_eq("drain_f", sb_q.size(), 0);
      tick();
      mon_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
